// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//   Sequencer for the GPIO pad-configuration serial chain. Fetches one
//   PAD_CTRL_BITS word per GPIO through an index/data port, shifts the words
//   out MSB first (word NUM_GPIO-1 first, so it travels to the farthest block),
//   then strobes serial_load so every block latches its word simultaneously.
//
//   Optional build macro: GPIO_LOADER_AUTOSTART_EN
//     defined   : the first clk edge after resetn deasserts acts as an accepted
//                 xfer_start (one-shot), loading the chain once after reset.
//     undefined : transfers start only on xfer_start.
//
// Ports
//   clk              system clock, all logic on posedge
//   resetn           asynchronous active-low reset
//   xfer_start       start request, sampled only while idle
//   xfer_abort       synchronous abort, back to idle without serial_load
//   xfer_busy        high from start acceptance until the done cycle
//   xfer_done        one-cycle pulse after serial_load has completed
//   cfg_idx          index of the config word being requested
//   cfg_data         config word for cfg_idx (combinational from cfg_idx)
//   serial_clock     chain shift clock
//   serial_data_out  chain serial data, changes only while serial_clock is low
//   serial_load      chain latch strobe
module gpio_serial_loader #(
   parameter int NUM_GPIO      = 19,
   parameter int PAD_CTRL_BITS = 13,
   parameter int CLK_DIV       = 2,
   parameter int IDX_W         = 5
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     xfer_start,
   input  logic                     xfer_abort,
   output logic                     xfer_busy,
   output logic                     xfer_done,
   output logic [IDX_W-1:0]         cfg_idx,
   input  logic [PAD_CTRL_BITS-1:0] cfg_data,
   output logic                     serial_clock,
   output logic                     serial_data_out,
   output logic                     serial_load
);

   localparam int PH_W = $clog2(CLK_DIV + 1);
   localparam int BC_W = $clog2(PAD_CTRL_BITS + 1);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(PAD_CTRL_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_GPIO - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_LOAD,
      S_GAP,
      S_DONE
   } state_t;

   state_t                   state_q,   state_d;
   logic [PH_W-1:0]          phase_q,   phase_d;
   logic [BC_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic [PAD_CTRL_BITS-1:0] word_q,    word_d;
   logic [IDX_W-1:0]         cfg_idx_q, cfg_idx_d;
   logic                     sclk_q,    sclk_d;
   logic                     sdo_q,     sdo_d;
   logic                     load_q,    load_d;
   logic                     busy_q,    busy_d;
   logic                     done_q,    done_d;
   logic                     reload_q,  reload_d;

   logic                     start_req;
   logic                     ph_wrap;
   logic [BC_W-1:0]          bit_nxt;

`ifdef GPIO_LOADER_AUTOSTART_EN
   // One-shot flag: set while in reset, cleared by the first clock edge.
   logic auto_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         auto_q <= 1'b1;
      end else begin
         auto_q <= 1'b0;
      end
   end

   assign start_req = xfer_start | auto_q;
`else
   assign start_req = xfer_start;
`endif

   assign ph_wrap = (phase_q == PH_LAST);
   assign bit_nxt = bit_cnt_q - 1'b1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         bit_cnt_q <= '0;
         word_q    <= '0;
         cfg_idx_q <= IDX_LAST;
         sclk_q    <= 1'b0;
         sdo_q     <= 1'b0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         reload_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         word_q    <= word_d;
         cfg_idx_q <= cfg_idx_d;
         sclk_q    <= sclk_d;
         sdo_q     <= sdo_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         reload_q  <= reload_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      word_d    = word_q;
      cfg_idx_d = cfg_idx_q;
      sclk_d    = sclk_q;
      sdo_d     = sdo_q;
      load_d    = load_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      reload_d  = 1'b0;

      if (xfer_abort && (state_q != S_IDLE)) begin
         // Abort never reaches LOAD, so pads keep their previous latch.
         state_d   = S_IDLE;
         phase_d   = '0;
         bit_cnt_d = '0;
         cfg_idx_d = IDX_LAST;
         sclk_d    = 1'b0;
         sdo_d     = 1'b0;
         load_d    = 1'b0;
         busy_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // cfg_idx already points at the farthest block's word here.
               if (start_req) begin
                  state_d   = S_SHIFT;
                  busy_d    = 1'b1;
                  word_d    = cfg_data;
                  bit_cnt_d = BC_LAST;
                  sdo_d     = cfg_data[PAD_CTRL_BITS-1];
                  sclk_d    = 1'b0;
                  phase_d   = '0;
               end
            end
            S_SHIFT: begin
               // cfg_idx moved on the previous edge, so cfg_data now holds the
               // next word; capture it in the first cycle of its low phase.
               if (reload_q) begin
                  word_d    = cfg_data;
                  bit_cnt_d = BC_LAST;
                  sdo_d     = cfg_data[PAD_CTRL_BITS-1];
               end
               if (!ph_wrap) begin
                  phase_d = phase_q + 1'b1;
               end else begin
                  phase_d = '0;
                  if (!sclk_q) begin
                     sclk_d = 1'b1;
                  end else begin
                     // End of a high phase: falling edge, next bit.
                     sclk_d = 1'b0;
                     if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_nxt;
                        sdo_d     = word_q[bit_nxt];
                     end else if (cfg_idx_q == '0) begin
                        state_d = S_LOAD;
                        sdo_d   = 1'b0;
                        load_d  = 1'b1;
                     end else begin
                        cfg_idx_d = cfg_idx_q - 1'b1;
                        reload_d  = 1'b1;
                     end
                  end
               end
            end
            S_LOAD: begin
               if (ph_wrap) begin
                  state_d = S_GAP;
                  load_d  = 1'b0;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
            S_GAP: begin
               if (ph_wrap) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  cfg_idx_d = IDX_LAST;
                  phase_d   = '0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
            S_DONE: begin
               // Unconditional return; a start seen in this cycle is dropped.
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign xfer_busy       = busy_q;
   assign xfer_done       = done_q;
   assign cfg_idx         = cfg_idx_q;
   assign serial_clock    = sclk_q;
   assign serial_data_out = sdo_q;
   assign serial_load     = load_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader
//   Two loader instances: A (2 blocks, 13 bits, divide-by-2) and B (1 block,
//   13 bits, divide-by-1). Each drives an abstract chain model: one flat shift
//   register clocked by serial_clock rises whose NUM*BITS contents are split
//   into per-block latches on the serial_load rise.
module tb_gpio_serial_loader;

   localparam int NA = 2;
   localparam int PA = 13;
   localparam int DA = 2;
   localparam int IA = 5;
   localparam int NB = 1;
   localparam int PB = 13;
   localparam int DB = 1;
   localparam int IB = 1;

   localparam int CYC_A = (NA * PA + 1) * 2 * DA;
   localparam int CYC_B = (NB * PB + 1) * 2 * DB;
   localparam int CHA   = NA * PA;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          start_a, abort_a, start_b, abort_b;
   logic          busy_a, done_a, sclk_a, sdo_a, load_a;
   logic          busy_b, done_b, sclk_b, sdo_b, load_b;
   logic [IA-1:0] cfg_idx_a;
   logic [IB-1:0] cfg_idx_b;
   logic [PA-1:0] cfg_data_a, cfg_data_b;
   logic [PA-1:0] cfg_a [NA];
   logic [PB-1:0] cfg_b;

   always_comb begin
      cfg_data_a = '0;
      if (cfg_idx_a < IA'(NA)) cfg_data_a = cfg_a[cfg_idx_a[0]];
   end
   assign cfg_data_b = cfg_b;

   gpio_serial_loader #(.NUM_GPIO(NA), .PAD_CTRL_BITS(PA), .CLK_DIV(DA), .IDX_W(IA)) u_a (
      .clk(clk), .resetn(resetn), .xfer_start(start_a), .xfer_abort(abort_a),
      .xfer_busy(busy_a), .xfer_done(done_a), .cfg_idx(cfg_idx_a), .cfg_data(cfg_data_a),
      .serial_clock(sclk_a), .serial_data_out(sdo_a), .serial_load(load_a));

   gpio_serial_loader #(.NUM_GPIO(NB), .PAD_CTRL_BITS(PB), .CLK_DIV(DB), .IDX_W(IB)) u_b (
      .clk(clk), .resetn(resetn), .xfer_start(start_b), .xfer_abort(abort_b),
      .xfer_busy(busy_b), .xfer_done(done_b), .cfg_idx(cfg_idx_b), .cfg_data(cfg_data_b),
      .serial_clock(sclk_b), .serial_data_out(sdo_b), .serial_load(load_b));

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- chain model / monitor, instance A ----------------
   logic [CHA-1:0] chain_a = '0;
   logic [PA-1:0]  lat_a [NA] = '{default: '0};
   int nbits_a = 0, load_cyc_a = 0, done_cnt_a = 0, viol_a = 0;
   int busy_rise_a = 0, done_at_a = 0, idx_chg_a = 0;
   logic busy_at_done_a = 1'b0;
   logic ps_a = 1'b0, pd_a = 1'b0, pl_a = 1'b0, pb_a = 1'b0, pdn_a = 1'b0;
   logic [IA-1:0] pidx_a = '0;

   always @(negedge clk) begin
      if (sclk_a && !ps_a) begin
         chain_a <= {chain_a[CHA-2:0], sdo_a};
         nbits_a <= nbits_a + 1;
      end
      if (sclk_a && ps_a && (sdo_a != pd_a)) viol_a <= viol_a + 1;
      if (load_a) begin
         load_cyc_a <= load_cyc_a + 1;
         if (!pl_a) for (int j = 0; j < NA; j++) lat_a[j] <= chain_a[j*PA +: PA];
      end
      if (busy_a && !pb_a) busy_rise_a <= cyc_cnt;
      if (done_a && !pdn_a) begin
         done_at_a      <= cyc_cnt;
         done_cnt_a     <= done_cnt_a + 1;
         busy_at_done_a <= busy_a;
      end
      if ((cfg_idx_a != pidx_a) && (cfg_idx_a == '0)) idx_chg_a <= cyc_cnt;
      ps_a   <= sclk_a;
      pd_a   <= sdo_a;
      pl_a   <= load_a;
      pb_a   <= busy_a;
      pdn_a  <= done_a;
      pidx_a <= cfg_idx_a;
   end

   // ---------------- chain model / monitor, instance B ----------------
   logic [PB-1:0] chain_b = '0;
   logic [PB-1:0] lat_b = '0;
   int load_cyc_b = 0, viol_b = 0, busy_rise_b = 0, done_at_b = 0;
   logic ps_b = 1'b0, pd_b = 1'b0, pl_b = 1'b0, pb_b = 1'b0, pdn_b = 1'b0;

   always @(negedge clk) begin
      if (sclk_b && !ps_b) chain_b <= {chain_b[PB-2:0], sdo_b};
      if (sclk_b && ps_b && (sdo_b != pd_b)) viol_b <= viol_b + 1;
      if (load_b) begin
         load_cyc_b <= load_cyc_b + 1;
         if (!pl_b) lat_b <= chain_b;
      end
      if (busy_b && !pb_b) busy_rise_b <= cyc_cnt;
      if (done_b && !pdn_b) done_at_b <= cyc_cnt;
      ps_b  <= sclk_b;
      pd_b  <= sdo_b;
      pl_b  <= load_b;
      pb_b  <= busy_b;
      pdn_b <= done_b;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Waits for xfer_done of a transfer already started, then checks timing,
   // latched block contents and the shifted bit stream against cfg_a.
   task automatic finish_a(input string tag, input int lc0, input int vc0);
      int t;
      t = 0;
      while (!done_a && t < 4 * CYC_A) begin
         @(negedge clk);
         t++;
      end
      #1;
      chk({tag, "_timeout"}, 32'(t < 4 * CYC_A), 32'd1);
      chk({tag, "_dur"}, 32'(done_at_a - busy_rise_a), 32'(CYC_A));
      chk({tag, "_busy_in_done"}, 32'(busy_at_done_a), 32'd0);
      chk({tag, "_lat1"}, 32'(lat_a[1]), 32'(cfg_a[1]));
      chk({tag, "_lat0"}, 32'(lat_a[0]), 32'(cfg_a[0]));
      chk({tag, "_stream"}, 32'(chain_a), 32'({cfg_a[1], cfg_a[0]}));
      chk({tag, "_load_len"}, 32'(load_cyc_a - lc0), 32'(DA));
      chk({tag, "_sdo_stable"}, 32'(viol_a - vc0), 32'd0);
      chk({tag, "_idx_lead"}, 32'(idx_chg_a - busy_rise_a), 32'(PA * 2 * DA));
   endtask

   task automatic xfer_a(input string tag);
      int lc0, vc0;
      lc0 = load_cyc_a;
      vc0 = viol_a;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      finish_a(tag, lc0, vc0);
   endtask

   task automatic xfer_b(input string tag);
      int lc0, vc0, t;
      lc0 = load_cyc_b;
      vc0 = viol_b;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      t = 0;
      while (!done_b && t < 4 * CYC_B) begin
         @(negedge clk);
         t++;
      end
      #1;
      chk({tag, "_timeout"}, 32'(t < 4 * CYC_B), 32'd1);
      chk({tag, "_dur"}, 32'(done_at_b - busy_rise_b), 32'(CYC_B));
      chk({tag, "_lat"}, 32'(lat_b), 32'(cfg_b));
      chk({tag, "_load_len"}, 32'(load_cyc_b - lc0), 32'(DB));
      chk({tag, "_sdo_stable"}, 32'(viol_b - vc0), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PA-1:0] exp1, exp0;
      int lc0, dc0, nb0, t;

      resetn  = 1'b0;
      start_a = 1'b0;
      abort_a = 1'b0;
      start_b = 1'b0;
      abort_b = 1'b0;
      cfg_a[1] = 13'h1803;
      cfg_a[0] = 13'h0403;
      cfg_b    = 13'h1FFF;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_sclk", 32'(sclk_a), 32'd0);
      chk("rst_sdo", 32'(sdo_a), 32'd0);
      chk("rst_load", 32'(load_a), 32'd0);
      chk("rst_idx", 32'(cfg_idx_a), 32'(NA - 1));
      chk("rst_idx_b", 32'(cfg_idx_b), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      xfer_a("dir");

      for (int i = 0; i < 4; i++) begin
         cfg_a[1] = 13'($urandom);
         cfg_a[0] = 13'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         xfer_a("rnd");
      end

      // Abort after 20 bits: pads must keep the last completed configuration.
      exp1 = cfg_a[1];
      exp0 = cfg_a[0];
      cfg_a[1] = ~exp1;
      cfg_a[0] = ~exp0;
      lc0 = load_cyc_a;
      dc0 = done_cnt_a;
      nb0 = nbits_a;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      t = 0;
      while ((nbits_a - nb0) < 20 && t < 4 * CYC_A) begin
         @(negedge clk);
         t++;
      end
      chk("abt_reach_bit20", 32'(t < 4 * CYC_A), 32'd1);
      abort_a = 1'b1;
      @(posedge clk);
      #1;
      abort_a = 1'b0;
      chk("abt_busy", 32'(busy_a), 32'd0);
      chk("abt_sclk", 32'(sclk_a), 32'd0);
      chk("abt_sdo", 32'(sdo_a), 32'd0);
      chk("abt_idx", 32'(cfg_idx_a), 32'(NA - 1));
      repeat (150) @(negedge clk);
      #1;
      chk("abt_no_load", 32'(load_cyc_a - lc0), 32'd0);
      chk("abt_no_done", 32'(done_cnt_a - dc0), 32'd0);
      chk("abt_keep1", 32'(lat_a[1]), 32'(exp1));
      chk("abt_keep0", 32'(lat_a[0]), 32'(exp0));

      // Asynchronous reset in the middle of SHIFT, then a clean transfer.
      cfg_a[1] = 13'($urandom);
      cfg_a[0] = 13'($urandom);
      lc0 = load_cyc_a;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (30) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("arst_busy", 32'(busy_a), 32'd0);
      chk("arst_sclk", 32'(sclk_a), 32'd0);
      chk("arst_sdo", 32'(sdo_a), 32'd0);
      chk("arst_load", 32'(load_a), 32'd0);
      chk("arst_idx", 32'(cfg_idx_a), 32'(NA - 1));
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("arst_no_load", 32'(load_cyc_a - lc0), 32'd0);
      xfer_a("post_rst");

      // xfer_start held high: DONE cycle ignores it, the IDLE cycle accepts it.
      lc0 = load_cyc_a;
      nb0 = viol_a;
      @(negedge clk);
      start_a = 1'b1;
      t = 0;
      while (!done_a && t < 4 * CYC_A) begin
         @(negedge clk);
         t++;
      end
      chk("hold_first_done", 32'(done_a), 32'd1);
      chk("hold_busy_done", 32'(busy_a), 32'd0);
      @(negedge clk);
      chk("hold_busy_idle", 32'(busy_a), 32'd0);
      chk("hold_done_pulse", 32'(done_a), 32'd0);
      @(negedge clk);
      chk("hold_restart", 32'(busy_a), 32'd1);
      start_a = 1'b0;
      lc0 = load_cyc_a;
      finish_a("hold2", lc0, nb0);

      // Instance B: single block, serial_clock at clk/2.
      xfer_b("b_dir");
      for (int i = 0; i < 3; i++) begin
         cfg_b = 13'($urandom);
         xfer_b("b_rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_serial_loader.md
Name: gpio_serial_loader

Overview:
- Sequencer for the GPIO pad-configuration serial chain.
- Fetches one PAD_CTRL_BITS config word per GPIO from the housekeeping register array through an index/data port.
- Serializes the words onto serial_clock/serial_data_out, farthest block first, then pulses serial_load so every gpio_control_block latches its new configuration at the same time.
- Sits in housekeeping and drives the head of the chain.

Parameters:
- NUM_GPIO, 19: number of gpio_control_block instances on the chain (>=1).
- PAD_CTRL_BITS, 13: config bits per block, MSB shifted first.
- CLK_DIV, 2: clk cycles per serial_clock half-period (>=1).
- IDX_W, 5: width of cfg_idx; must satisfy 2**IDX_W >= NUM_GPIO.

Ports:
- clk  in  1  system clock; all logic is posedge clk.
- resetn  in  1  asynchronous active-low reset.
- xfer_start  in  1  start request, sampled only in IDLE.
- xfer_abort  in  1  synchronous abort; returns to IDLE with no serial_load pulse.
- xfer_busy  out  1  high from start acceptance until done.
- xfer_done  out  1  one-cycle pulse when serial_load has completed.
- cfg_idx  out  IDX_W  index of the GPIO word being requested.
- cfg_data  in  PAD_CTRL_BITS  config word for cfg_idx; combinational from cfg_idx.
- serial_clock  out  1  chain shift clock.
- serial_data_out  out  1  chain serial data; changes only while serial_clock is low.
- serial_load  out  1  chain latch strobe.

Behaviour:
- Reset values: xfer_busy=0, xfer_done=0, serial_clock=0, serial_data_out=0, serial_load=0, cfg_idx=NUM_GPIO-1, state=IDLE, all counters=0.
- States: IDLE, SHIFT, LOAD, GAP, DONE.
- Phase counter runs 0..CLK_DIV-1 and wraps at CLK_DIV-1; it is the only thing that advances half-periods.
- IDLE:
  - On xfer_start=1 (edge E0): go to SHIFT, busy=1, word_reg<=cfg_data (cfg_idx is already NUM_GPIO-1), bit_cnt=PAD_CTRL_BITS-1, serial_data_out<=cfg_data[MSB], serial_clock=0.
- SHIFT:
  - Each bit lasts 2*CLK_DIV cycles: CLK_DIV with serial_clock low, then CLK_DIV high.
  - serial_data_out=word_reg[bit_cnt] for the whole bit; downstream captures on the serial_clock rising edge.
  - At the end of each high phase, serial_clock->0 and bit_cnt decrements, with serial_data_out updated at that same edge.
  - After bit 0 of word k>0: cfg_idx<=k-1. At the following edge (the next low-phase start), word_reg<=cfg_data and bit_cnt<=PAD_CTRL_BITS-1. cfg_idx therefore leads the word capture by one cycle.
  - After bit 0 of word 0: go to LOAD. cfg_idx stays 0 until DONE.
- Chain ordering:
  - Word NUM_GPIO-1 goes first, MSB first; word 0, bit 0 is the last bit sent.
  - Each block adds exactly PAD_CTRL_BITS of delay; its negedge output flop only retimes and adds no bit.
- LOAD: serial_clock=0, serial_data_out=0, serial_load=1 for CLK_DIV cycles.
- GAP: serial_load=0 for CLK_DIV cycles.
- DONE:
  - xfer_done=1 for one cycle, busy=0 in that same cycle, cfg_idx<=NUM_GPIO-1, then IDLE.
  - A new xfer_start in the DONE cycle is ignored.
- Cycle count: xfer_done is asserted exactly (NUM_GPIO*PAD_CTRL_BITS+1)*2*CLK_DIV cycles after E0.
- Overlap and abort:
  - xfer_start while busy is ignored.
  - xfer_abort in any non-IDLE state: next edge serial_clock=0, serial_data_out=0, serial_load=0, busy=0, cfg_idx=NUM_GPIO-1, no xfer_done, state IDLE. Pads keep their previous config.
  - xfer_abort has priority over xfer_start.
- Asynchronous reset mid-transfer forces all reset values immediately. No serial_load is issued.
- Edge cases:
  - NUM_GPIO=1: one word, cfg_idx is constant 0.
  - CLK_DIV=1: serial_clock toggles every clk cycle (clk/2).

Optional Feature:
- Macro: GPIO_LOADER_AUTOSTART_EN.
- Defined: the first clk edge after resetn deasserts behaves as an accepted xfer_start, so the full chain is loaded once automatically after reset. This is a one-shot flag set by reset and cleared at the first edge. xfer_abort during it behaves normally.
- Not defined: transfers start only on xfer_start.

Test Plan:
- NUM_GPIO=2, PAD_CTRL_BITS=13, CLK_DIV=2, cfg[1]=13'h1803, cfg[0]=13'h0403, two chained gpio_control_block models, pulse xfer_start -> busy for 108 cycles, then xfer_done; block1 latches 13'h1803, block0 latches 13'h0403; serial_load high exactly 2 cycles.
- Same setup, sample serial_data_out at each serial_clock rise -> sequence is 13'h1803 MSB-first followed by 13'h0403 MSB-first; data never changes while serial_clock=1; cfg_idx changes from 1 to 0 one cycle before the 14th bit's low phase.
- xfer_abort asserted at bit 20 -> next cycle busy=0, serial_clock=0; no serial_load and no done; models keep their prior latched values.
- resetn pulled low mid-SHIFT -> all outputs go to 0 asynchronously and cfg_idx=1; a new xfer_start after release completes normally in 108 cycles.
- xfer_start held high continuously -> back-to-back transfers, each 108 cycles plus 1 idle cycle (start ignored in the DONE cycle).
- CLK_DIV=1, NUM_GPIO=1, cfg[0]=13'h1FFF, with GPIO_LOADER_AUTOSTART_EN defined -> transfer starts with no xfer_start; done at cycle 28 after reset release; block latches 13'h1FFF.
